// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between four byte requesters, the arbiter and one UART transmitter.
// The master modport is the arbiter side; the slave modport is the requester/transmitter side.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic [15:0] tx_count;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, arb_busy, tx_count
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, arb_busy, tx_count
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds four byte channels into a single UART transmitter.
// Define UART_TX_ARB_HDR_EN to precede each data byte with a header byte {HDR_BASE[7:2], channel}.
module uart_tx_arbiter #(
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
);

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, SEND_HDR, WAIT_HDR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;
`endif

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] next_grant;
    logic [1:0] cand;
    logic       found;
    logic [7:0] cur_byte;

`ifdef UART_TX_ARB_HDR_EN
    logic [7:0] byte_reg;
`else
    logic       unused_hdr_base;
    assign unused_hdr_base = ^HDR_BASE;
`endif

    assign cur_byte = bus.req_data[{grant_id_q(), 3'b000} +: 8];

    function automatic logic [1:0] grant_id_q();
        return bus.grant_id;
    endfunction

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        next_grant = last_grant;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && bus.req_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= 2'd3;
            bus.grant_id  <= 2'd0;
            bus.req_ready <= 4'b0000;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.arb_busy  <= 1'b0;
            bus.tx_count  <= 16'h0000;
`ifdef UART_TX_ARB_HDR_EN
            byte_reg      <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found && !bus.tx_busy) begin
                        state         <= LOAD;
                        bus.grant_id  <= next_grant;
                        bus.req_ready <= 4'b0001 << next_grant;
                        bus.arb_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bus.req_ready <= 4'b0000;
                    last_grant    <= bus.grant_id;
                    bus.tx_start  <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
                    byte_reg      <= cur_byte;
                    bus.tx_data   <= {HDR_BASE[7:2], bus.grant_id};
                    state         <= SEND_HDR;
`else
                    bus.tx_data   <= cur_byte;
                    state         <= SEND;
`endif
                end
                SEND: begin
                    if (bus.tx_busy) begin
                        bus.tx_start <= 1'b0;
                        state        <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        bus.tx_count <= bus.tx_count + 16'd1;
                        bus.arb_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                SEND_HDR: begin
                    if (bus.tx_busy) begin
                        bus.tx_start <= 1'b0;
                        state        <= WAIT_HDR;
                    end
                end
                // Header completion is not a data byte, so tx_count stays put here.
                WAIT_HDR: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= byte_reg;
                        state        <= SEND;
                    end
                end
`endif
                default: begin
                    state         <= IDLE;
                    bus.tx_start  <= 1'b0;
                    bus.req_ready <= 4'b0000;
                    bus.arb_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-plus-random bench for uart_tx_arbiter; a round-robin model predicts grants, bytes and counts.
// Header episodes are checked as well when UART_TX_ARB_HDR_EN is defined.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_last;
    int model_count;
    logic [7:0] chan_byte [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        bus.req_valid = valid;
        bus.req_data  = data;
        for (int c = 0; c < 4; c++) chan_byte[c] = data[8*c +: 8];
    endtask

    // First valid channel after the previous winner, wrapping modulo 4.
    function automatic int pickChannel(input int last, input logic [3:0] valid);
        for (int off = 1; off <= 4; off++)
            if (valid[(last + off) % 4]) return (last + off) % 4;
        return -1;
    endfunction

    task automatic runGrant(input int busy_delay, input int busy_len, output int wait_cycles);
        int exp_ch;
        int n;
        exp_ch = pickChannel(model_last, bus.req_valid);
        n = 0;
        while (bus.req_ready === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        wait_cycles = n;
        checkOutput("grant_timeout", 32'(n < 20), 32'd1);
        checkOutput("req_ready", 32'(bus.req_ready), 32'd1 << exp_ch);
        checkOutput("grant_id", 32'(bus.grant_id), exp_ch);
        checkOutput("arb_busy_load", 32'(bus.arb_busy), 32'd1);
        model_last = exp_ch;
        tick();
        checkOutput("ready_pulse", 32'(bus.req_ready), 32'd0);
`ifdef UART_TX_ARB_HDR_EN
        checkOutput("hdr_start", 32'(bus.tx_start), 32'd1);
        checkOutput("hdr_data", 32'(bus.tx_data), 32'(160 + exp_ch));
        bus.tx_busy = 1'b1;
        tick();
        checkOutput("hdr_start_drop", 32'(bus.tx_start), 32'd0);
        repeat (busy_len) tick();
        bus.tx_busy = 1'b0;
        tick();
        checkOutput("hdr_no_count", 32'(bus.tx_count), model_count);
`endif
        checkOutput("tx_start", 32'(bus.tx_start), 32'd1);
        checkOutput("tx_data", 32'(bus.tx_data), 32'(chan_byte[exp_ch]));
        repeat (busy_delay) begin
            tick();
            checkOutput("tx_start_hold", 32'(bus.tx_start), 32'd1);
        end
        bus.tx_busy = 1'b1;
        tick();
        checkOutput("tx_start_drop", 32'(bus.tx_start), 32'd0);
        repeat (busy_len) tick();
        checkOutput("tx_data_hold", 32'(bus.tx_data), 32'(chan_byte[exp_ch]));
        bus.tx_busy = 1'b0;
        tick();
        model_count = (model_count + 1) % 65536;
        checkOutput("tx_count", 32'(bus.tx_count), model_count);
        checkOutput("arb_busy_idle", 32'(bus.arb_busy), 32'd0);
        checkOutput("idle_gap", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        checkOutput({tag, "_arb_busy"}, 32'(bus.arb_busy), 32'd0);
        checkOutput({tag, "_tx_count"}, 32'(bus.tx_count), 32'd0);
        checkOutput({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wc;
        int n;
        reset_n     = 1'b0;
        bus.tx_busy = 1'b0;
        applyStimulus(4'hF, 32'h0);
        model_last  = 3;
        model_count = 0;
        tick();
        tick();
        checkResetValues("reset");

        // Single request on channel 2 with byte 0x55.
        applyStimulus(4'b0000, 32'h0);
        reset_n = 1'b1;
        tick();
        applyStimulus(4'b0100, 32'h0055_0000);
        runGrant(1, 2, wc);
        applyStimulus(4'b0000, 32'h0);

        // All four valid after reset: 0,1,2,3,0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_last  = 3;
        model_count = 0;
        checkResetValues("reset2");
        applyStimulus(4'hF, 32'h4433_2211);
        for (int i = 0; i < 5; i++) runGrant(0, 1, wc);

        // Channels 1 and 3 only: 1,3,1,3.
        applyStimulus(4'b1010, 32'hA500_5A00);
        for (int i = 0; i < 4; i++) runGrant(i % 3, 1, wc);

        // Transmitter busy externally: nothing happens until it falls.
        bus.tx_busy = 1'b1;
        applyStimulus(4'b0001, 32'h0000_00C3);
        repeat (4) begin
            tick();
            checkOutput("busy_block_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("busy_block_start", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_busy = 1'b0;
        runGrant(0, 2, wc);
        checkOutput("grant_latency", 32'(wc <= 2), 32'd1);

        // Reset asserted in the middle of WAIT_DONE aborts the byte.
        applyStimulus(4'b0010, 32'h0000_9900);
        n = 0;
        while (bus.req_ready === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("abort_grant_id", 32'(bus.grant_id), 32'd1);
        tick();
        bus.tx_busy = 1'b1;
        tick();
        checkOutput("abort_in_wait", 32'(bus.arb_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        tick();
        reset_n     = 1'b1;
        model_last  = 3;
        model_count = 0;
        applyStimulus(4'b0011, 32'h0000_7788);
        repeat (3) begin
            tick();
            checkOutput("post_reset_hold", 32'(bus.req_ready), 32'd0);
            checkOutput("post_reset_start", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_busy = 1'b0;
        runGrant(0, 1, wc);

        // Random masks, bytes and transmitter timing.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), $urandom);
            runGrant(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), wc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
